// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap/interrupt sequencer: address width, FSM
// state and cause encodings, and the captured trap context.
package trap_ctrl_pkg;

  localparam int unsigned HBIT_ADDR = 47;
  localparam int unsigned ADDR_W    = HBIT_ADDR + 1;
  localparam int unsigned CAUSE_W   = 4;
  localparam int unsigned ST_W      = 2;

  localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [ST_W-1:0] ST_DRAIN   = 2'd1;
  localparam logic [ST_W-1:0] ST_VECTOR  = 2'd2;
  localparam logic [ST_W-1:0] ST_HANDLER = 2'd3;

  localparam logic [CAUSE_W-1:0] CAUSE_SWI      = 4'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_IRQ_BASE = 4'd1;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    addr_t               target;
    addr_t               ret;
    logic [CAUSE_W-1:0]  cause;
  } trap_ctx_t;

  // Handler address for IRQ line idx; wraps at the address width.
  function automatic addr_t irq_vector(input addr_t base, input addr_t stride,
                                       input addr_t idx);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/trap_arb.sv
// Combinational trap arbiter: SWI beats IRQs; among enabled pending IRQs the
// lowest index wins.
module trap_arb #(
  parameter int unsigned NUM_IRQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic               swi_req,
  input  logic [NUM_IRQ-1:0] pend,
  input  logic               ie,
  output logic               grant_c,
  output logic               swi_c,
  output logic [IDX_W-1:0]   idx_c
);

  always_comb begin
    grant_c = 1'b0;
    swi_c   = 1'b0;
    idx_c   = '0;
    if (swi_req) begin
      grant_c = 1'b1;
      swi_c   = 1'b1;
    end else if (ie) begin
      // Scan downward so the last hit is the lowest index.
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
        if (pend[i]) begin
          grant_c = 1'b1;
          idx_c   = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/interrupt sequencer: accepts SWI/IRQ traps at EX, drains the pipeline,
// issues a single redirect with LR write, and tracks handler residency to RETI.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ      = 4,
  parameter addr_t       VEC_BASE     = 48'h0000_0000_0200,
  parameter addr_t       VEC_STRIDE   = 48'h10,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic               iw_clk,
  input  logic               iw_rst_n,
  input  logic [NUM_IRQ-1:0] iw_irq,
  input  logic               iw_ie,
  input  logic               iw_ex_valid,
  input  logic [ADDR_W-1:0]  iw_ex_pc,
  input  logic               iw_ex_branch_taken,
  input  logic [ADDR_W-1:0]  iw_ex_branch_pc,
  input  logic               iw_swi_req,
  input  logic [ADDR_W-1:0]  iw_swi_vec,
  input  logic               iw_reti,
  output logic               ow_flush,
  output logic               ow_redirect_valid,
  output logic [ADDR_W-1:0]  ow_redirect_pc,
  output logic               ow_lr_we,
  output logic [ADDR_W-1:0]  ow_lr_val,
  output logic               ow_ie_clr,
  output logic               ow_ie_set,
  output logic [CAUSE_W-1:0] ow_cause,
  output logic               ow_in_handler,
  output logic               ow_double_trap
);

  localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  logic [ST_W-1:0]    state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_IRQ-1:0] irq_q, pend_q, pend_d, pend_clr, irq_rise;
  trap_ctx_t          ctx_q, ctx_d;

  logic               grant_c, swi_c;
  logic [IDX_W-1:0]   idx_c;

  logic               flush_d, redirect_d, ie_clr_d, ie_set_d, in_handler_d, double_trap_d;
  addr_t              redirect_pc_d, lr_val_d;

  assign irq_rise = iw_irq & ~irq_q;

  trap_arb #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .swi_req (iw_ex_valid & iw_swi_req),
    .pend    (pend_q),
    .ie      (iw_ie),
    .grant_c (grant_c),
    .swi_c   (swi_c),
    .idx_c   (idx_c)
  );

  // Next state, trap capture, pending update and next output values.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ctx_d         = ctx_q;
    pend_clr      = '0;
    ie_set_d      = 1'b0;
    double_trap_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (iw_ex_valid && grant_c) begin
          state_d   = ST_DRAIN;
          cnt_d     = '0;
          ctx_d.ret = iw_ex_branch_taken ? iw_ex_branch_pc : iw_ex_pc + ADDR_W'(1);
          if (swi_c) begin
            ctx_d.target = iw_swi_vec;
            ctx_d.cause  = CAUSE_SWI;
          end else begin
            ctx_d.target    = irq_vector(VEC_BASE, VEC_STRIDE, ADDR_W'(idx_c));
            ctx_d.cause     = CAUSE_IRQ_BASE + CAUSE_W'(idx_c);
            pend_clr[idx_c] = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) state_d = ST_VECTOR;
        else                                   cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_VECTOR: state_d = ST_HANDLER;
      ST_HANDLER: begin
        // RETI takes precedence over a coincident SWI.
        if (iw_ex_valid && iw_reti) begin
          state_d  = ST_IDLE;
          ie_set_d = 1'b1;
        end else if (iw_ex_valid && iw_swi_req) begin
          double_trap_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pend_d = (pend_q & ~pend_clr) | irq_rise;

    flush_d       = (state_d == ST_DRAIN) || (state_d == ST_VECTOR);
    redirect_d    = (state_d == ST_VECTOR);
    ie_clr_d      = redirect_d;
    in_handler_d  = (state_d == ST_HANDLER);
    redirect_pc_d = redirect_d ? ctx_d.target : '0;
    lr_val_d      = redirect_d ? ctx_d.ret    : '0;
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_q           <= ST_IDLE;
      cnt_q             <= '0;
      irq_q             <= '0;
      pend_q            <= '0;
      ctx_q             <= '0;
      ow_flush          <= 1'b0;
      ow_redirect_valid <= 1'b0;
      ow_redirect_pc    <= '0;
      ow_lr_we          <= 1'b0;
      ow_lr_val         <= '0;
      ow_ie_clr         <= 1'b0;
      ow_ie_set         <= 1'b0;
      ow_in_handler     <= 1'b0;
      ow_double_trap    <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      irq_q             <= iw_irq;
      pend_q            <= pend_d;
      ctx_q             <= ctx_d;
      ow_flush          <= flush_d;
      ow_redirect_valid <= redirect_d;
      ow_redirect_pc    <= redirect_pc_d;
      ow_lr_we          <= redirect_d;
      ow_lr_val         <= lr_val_d;
      ow_ie_clr         <= ie_clr_d;
      ow_ie_set         <= ie_set_d;
      ow_in_handler     <= in_handler_d;
      ow_double_trap    <= double_trap_d;
    end
  end

  assign ow_cause = ctx_q.cause;

endmodule
